// File: rtl/user_input_entry.sv
// rtl/user_input_entry.sv - five-button BCD guess entry feeding the 7-segment display driver
// Buttons are synchronised and debounced, then drive an IDLE/ENTRY/SUBMITTED editor.
module user_input_entry #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic        fastClk,
   input  logic        rst,
   input  logic        enable,
   input  logic        btnUp,
   input  logic        btnDown,
   input  logic        btnLeft,
   input  logic        btnRight,
   input  logic        btnCenter,
   output logic [15:0] userInput,
   output logic        inputReady,
   output logic [1:0]  cursor
);

   localparam logic [7:0] CNT_LAST  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] ENTRY     = 2'd1;
   localparam logic [1:0] SUBMITTED = 2'd2;
   localparam int B_RIGHT  = 0;
   localparam int B_LEFT   = 1;
   localparam int B_DOWN   = 2;
   localparam int B_UP     = 3;
   localparam int B_CENTER = 4;

   logic [4:0] rawBtn;
   logic [4:0] sync1;
   logic [4:0] sync2;
   logic [4:0] debounced;
   logic [4:0] debPrev;
   logic [4:0] press;
   logic [7:0] debCnt [5];
   logic [1:0] state;
   logic [3:0] selDigit;
   logic [3:0] incDigit;
   logic [3:0] decDigit;

   assign rawBtn = {btnCenter, btnUp, btnDown, btnLeft, btnRight};

   // press is registered so every action lands DEBOUNCE_CYCLES+3 edges after the first sample
   always_ff @(posedge fastClk or posedge rst) begin
      if (rst) begin
         sync1     <= '0;
         sync2     <= '0;
         debounced <= '0;
         debPrev   <= '0;
         press     <= '0;
         for (int i = 0; i < 5; i++) debCnt[i] <= '0;
      end else begin
         sync1   <= rawBtn;
         sync2   <= sync1;
         debPrev <= debounced;
         press   <= debounced & ~debPrev;
         for (int i = 0; i < 5; i++) begin
            if (sync2[i] != debounced[i]) begin
               if (debCnt[i] == CNT_LAST) begin
                  debounced[i] <= ~debounced[i];
                  debCnt[i]    <= '0;
               end else begin
                  debCnt[i] <= debCnt[i] + 8'd1;
               end
            end else begin
               debCnt[i] <= '0;
            end
         end
      end
   end

   function automatic logic [15:0] setDigit(input logic [15:0] v, input logic [1:0] idx,
                                            input logic [3:0] d);
      logic [15:0] r;
      r = v;
      case (idx)
         2'd0:    r[15:12] = d;
         2'd1:    r[11:8]  = d;
         2'd2:    r[7:4]   = d;
         default: r[3:0]   = d;
      endcase
      return r;
   endfunction

   always_comb begin
      selDigit = 4'd0;
      case (cursor)
         2'd0:    selDigit = userInput[15:12];
         2'd1:    selDigit = userInput[11:8];
         2'd2:    selDigit = userInput[7:4];
         default: selDigit = userInput[3:0];
      endcase
      incDigit = (selDigit == 4'd9) ? 4'd0 : selDigit + 4'd1;
      decDigit = (selDigit == 4'd0) ? 4'd9 : selDigit - 4'd1;
   end

   always_ff @(posedge fastClk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         userInput  <= '0;
         inputReady <= 1'b0;
         cursor     <= '0;
      end else begin
         case (state)
            IDLE: begin
               inputReady <= 1'b0;
               if (enable) begin
                  userInput <= '0;
                  cursor    <= '0;
                  state     <= ENTRY;
               end
            end
            ENTRY: begin
               if (!enable) begin
                  state <= IDLE;
               end else if (press[B_CENTER]) begin
                  inputReady <= 1'b1;
                  state      <= SUBMITTED;
               end else if (press[B_UP]) begin
                  userInput <= setDigit(userInput, cursor, incDigit);
               end else if (press[B_DOWN]) begin
                  userInput <= setDigit(userInput, cursor, decDigit);
               end else if (press[B_LEFT]) begin
                  cursor <= cursor - 2'd1;
               end else if (press[B_RIGHT]) begin
                  cursor <= cursor + 2'd1;
               end
            end
            SUBMITTED: begin
               if (!enable) begin
                  inputReady <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_user_input_entry.sv
// tb/tb_user_input_entry.sv - self-checking bench for user_input_entry
// Behavioural model of accepted presses and digit editing, compared every cycle.
module tb_user_input_entry;

   localparam int D = 4;
   localparam logic [4:0] MC = 5'b10000;
   localparam logic [4:0] MU = 5'b01000;
   localparam logic [4:0] MD = 5'b00100;
   localparam logic [4:0] ML = 5'b00010;
   localparam logic [4:0] MR = 5'b00001;

   logic        fastClk = 1'b0;
   logic        rst;
   logic        enable;
   logic        btnUp, btnDown, btnLeft, btnRight, btnCenter;
   logic [15:0] userInput;
   logic        inputReady;
   logic [1:0]  cursor;
   logic [4:0]  raw;

   int nVec  = 0;
   int nFail = 0;

   always #5 fastClk = ~fastClk;

   user_input_entry #(.DEBOUNCE_CYCLES(D)) dut (
      .fastClk(fastClk), .rst(rst), .enable(enable),
      .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft),
      .btnRight(btnRight), .btnCenter(btnCenter),
      .userInput(userInput), .inputReady(inputReady), .cursor(cursor)
   );

   assign raw = {btnCenter, btnUp, btnDown, btnLeft, btnRight};

   // model: a level held for D raw samples is accepted; a rising acceptance acts 4 edges later
   int       mDig [4] = '{0, 0, 0, 0};
   int       mCur = 0;
   bit       mReady = 0;
   int       mPhase = 0;
   bit [4:0] acc = '0;
   int       run [5] = '{0, 0, 0, 0, 0};
   bit [4:0] pend [4] = '{5'd0, 5'd0, 5'd0, 5'd0};
   bit [4:0] mAct;

   function automatic logic [15:0] mUser();
      return 16'(mDig[0] * 4096 + mDig[1] * 256 + mDig[2] * 16 + mDig[3]);
   endfunction

   always @(posedge fastClk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin mDig[i] = 0; pend[i] = '0; end
         for (int b = 0; b < 5; b++) run[b] = 0;
         acc = '0; mCur = 0; mReady = 0; mPhase = 0;
      end else begin
         mAct = pend[0];
         for (int i = 0; i < 3; i++) pend[i] = pend[i+1];
         pend[3] = '0;
         for (int b = 0; b < 5; b++) begin
            if (raw[b] != acc[b]) begin
               run[b]++;
               if (run[b] == D) begin
                  acc[b] = ~acc[b];
                  run[b] = 0;
                  if (acc[b]) pend[3][b] = 1'b1;
               end
            end else begin
               run[b] = 0;
            end
         end
         case (mPhase)
            0: if (enable) begin
                  for (int i = 0; i < 4; i++) mDig[i] = 0;
                  mCur = 0; mPhase = 1;
               end
            1: begin
               if (!enable) mPhase = 0;
               else if (mAct[4]) begin mReady = 1; mPhase = 2; end
               else if (mAct[3]) mDig[mCur] = (mDig[mCur] + 1) % 10;
               else if (mAct[2]) mDig[mCur] = (mDig[mCur] + 9) % 10;
               else if (mAct[1]) mCur = (mCur + 3) % 4;
               else if (mAct[0]) mCur = (mCur + 1) % 4;
            end
            default: if (!enable) begin mReady = 0; mPhase = 0; end
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge fastClk) begin
      chk("userInput", 32'(userInput), 32'(mUser()));
      chk("cursor", 32'(cursor), 32'(mCur));
      chk("inputReady", 32'(inputReady), 32'(mReady));
      for (int n = 0; n < 4; n++)
         chk("digitRange", 32'(((userInput >> (4 * n)) & 16'hF) <= 16'd9), 32'd1);
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge fastClk); #2; end
   endtask

   task automatic setBtn(input logic [4:0] m);
      {btnCenter, btnUp, btnDown, btnLeft, btnRight} = m;
   endtask

   task automatic press(input logic [4:0] m);
      setBtn(m); tick(6); setBtn('0); tick(12);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; setBtn('0);
      tick(3);
      chk("resetUser", 32'(userInput), 32'h0);
      chk("resetCursor", 32'(cursor), 32'h0);
      chk("resetReady", 32'(inputReady), 32'h0);
      rst = 1'b0; tick(2);
      enable = 1'b1; tick(1);

      // single held press: update exactly at E+7
      setBtn(MU); tick(7);
      chk("t1Before", 32'(userInput), 32'h0);
      tick(1);
      chk("t1At", 32'(userInput), 32'h1000);
      tick(2); setBtn('0); tick(12);
      chk("t1Single", 32'(userInput), 32'h1000);
      chk("t1Cursor", 32'(cursor), 32'h0);

      enable = 1'b0; tick(2); enable = 1'b1; tick(2);
      chk("t2Start", 32'(userInput), 32'h0);
      press(MD); press(MR); repeat (3) press(MU); press(MR); press(MR); press(MU);
      chk("t2User", 32'(userInput), 32'h9301);
      chk("t2Cursor", 32'(cursor), 32'h3);
      press(MR);
      chk("t2Wrap", 32'(cursor), 32'h0);

      for (int w = 1; w < 4; w++) begin
         setBtn(MU); tick(w); setBtn('0); tick(10);
         chk("t3Glitch", 32'(userInput), 32'h9301);
      end
      setBtn(MU); tick(4); setBtn('0); tick(12);
      chk("t3Accept", 32'(userInput), 32'h0301);

      setBtn(MC | MU); tick(7);
      chk("t4Before", 32'(inputReady), 32'h0);
      tick(1);
      chk("t4Ready", 32'(inputReady), 32'h1);
      chk("t4User", 32'(userInput), 32'h0301);
      tick(2); setBtn('0); tick(12);
      press(MU); press(MR); press(MC);
      chk("t4Frozen", 32'(userInput), 32'h0301);
      chk("t4CurFrozen", 32'(cursor), 32'h0);
      enable = 1'b0; tick(1);
      chk("t4Drop", 32'(inputReady), 32'h0);
      chk("t4Hold", 32'(userInput), 32'h0301);
      tick(2);

      enable = 1'b1; tick(2);
      for (int c = 0; c < 4; c++) begin
         press(MD);
         chk("t5Down", 32'(userInput), 32'h9 << (4 * (3 - c)));
         press(MU);
         chk("t5Up", 32'(userInput), 32'h0);
         press(MR);
      end
      chk("t5Cursor", 32'(cursor), 32'h0);

      repeat (4) press(MU); press(MR); repeat (2) press(MU); press(MR); press(MR);
      repeat (3) press(MD);
      chk("t6User", 32'(userInput), 32'h4207);
      chk("t6Cursor", 32'(cursor), 32'h3);
      setBtn(MU); #1 rst = 1'b1; #1;
      chk("t6RstUser", 32'(userInput), 32'h0);
      chk("t6RstCursor", 32'(cursor), 32'h0);
      chk("t6RstReady", 32'(inputReady), 32'h0);
      tick(2); rst = 1'b0;
      tick(1);
      chk("t6Reentry", 32'(userInput), 32'h0);
      tick(9); setBtn('0); tick(12);
      chk("t6HeldPress", 32'(userInput), 32'h1000);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule

// File: doc/user_input_entry.md
Name: user_input_entry

Overview:
Producer side of the userInput/inputReady interface that the 7-segment display driver consumes. Turns five raw pushbuttons into a 4-digit BCD guess: up/down edit the selected digit, left/right move the cursor, center submits. Synchronises and debounces every button on fastClk. Asserts inputReady on submit and holds it until the input phase ends.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive fastClk cycles a synchronised level must stay stable before it is accepted (legal range 2..255)

Ports:
fastClk  input  1  system clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  input phase active; driven by ~displayPhase
btnUp  input  1  raw button; increment selected digit
btnDown  input  1  raw button; decrement selected digit
btnLeft  input  1  raw button; cursor toward bits[15:12]
btnRight  input  1  raw button; cursor toward bits[3:0]
btnCenter  input  1  raw button; submit
userInput  output  16  four BCD digits; bits[15:12] are the leftmost digit
inputReady  output  1  guess submitted and stable
cursor  output  2  selected digit; 0 selects bits[15:12], 3 selects bits[3:0]

Behaviour:
- Reset (async, any time, including mid-entry): userInput=16'h0000, inputReady=0, cursor=0, FSM=IDLE. All synchroniser flops, debounced levels, previous-level flops and counters are cleared to 0.
- Per button:
  - 2-flop synchroniser.
  - Debounce counter increments on each cycle where the synchronised level differs from the debounced level. It clears when the two match.
  - When the counter has counted DEBOUNCE_CYCLES mismatching cycles, the debounced level toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES is ignored.
  - press = debounced & ~debounced_prev, a one-cycle pulse on each accepted 0->1 transition. Releases produce no pulse.
- Latency: a button held high from the first sampling edge E causes its userInput/cursor/inputReady update on edge E+DEBOUNCE_CYCLES+3 (7 edges at default). A held button produces exactly one action, with no auto-repeat.
- A button held high through reset release is treated as a new press after debounce.
- Only one action per cycle. Priority: center > up > down > left > right. Lower-priority presses in the same cycle are dropped.
- FSM IDLE:
  - Buttons are ignored and inputReady=0.
  - While enable=0, userInput holds its value.
  - When enable=1 is sampled: userInput<=0, cursor<=0, next state ENTRY.
- FSM ENTRY:
  - up: selected digit +1, with 9 wrapping to 0.
  - down: selected digit -1, with 0 wrapping to 9.
  - left: cursor-1, with 0 wrapping to 3.
  - right: cursor+1, with 3 wrapping to 0.
  - center: inputReady<=1, next state SUBMITTED. userInput is unchanged in that cycle.
  - enable=0 sampled: next state IDLE. This takes precedence over any press in the same cycle, and userInput holds.
- FSM SUBMITTED:
  - userInput and cursor are frozen, inputReady=1, and all presses are ignored.
  - enable=0 sampled: inputReady<=0, next state IDLE.
- Digits never leave 0..9. Codes A-F are reserved for the display's letter glyphs.
- Arithmetic: digit update is 4-bit with explicit wrap compare; the cursor is a 2-bit natural wrap.

Test Plan:
1. Reset, then enable=1, then btnUp held 10 cycles -> userInput=16'h1000 at edge E+7, single increment, cursor=0.
2. From 16'h0000: press down once, right, up x3, right, right, up -> userInput=16'h9301, cursor=3. Then right -> cursor=0.
3. btnUp pulses of 1, 2 and 3 cycles (DEBOUNCE_CYCLES=4) -> userInput unchanged. A 4-cycle-stable pulse -> one increment.
4. btnCenter and btnUp asserted on the same edge -> inputReady=1 at E+7 with userInput unchanged. Later presses are ignored. enable=0 -> inputReady=0 on the next edge, userInput held.
5. Digit at 9 then up -> 0. Digit at 0 then down -> 9. Across all 4 digits, no A-F value ever appears (assertion).
6. rst pulsed mid-ENTRY with userInput=16'h4207 -> all outputs 0 immediately. After release with enable=1 the FSM re-enters ENTRY and userInput=0.
